// File: rtl/block_scheduler_scorer.sv
// Game-state engine: song clock, note-block table scan, saber hit/miss scoring.
// Latency: entry i judged in scan cycle i, pulses/mask commit one cycle later; no backpressure, writes always accepted.
module block_scheduler_scorer #(
    parameter int NUM_BLOCKS      = 8,
    parameter int CYCLES_PER_TICK = 10,
    parameter int TIME_WIDTH      = 12,
    parameter int HIT_RADIUS      = 64,
    parameter int LOOKAHEAD       = 64,
    localparam int IW             = $clog2(NUM_BLOCKS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  wr_en_in,
    input  logic [IW-1:0]         wr_index_in,
    input  logic [11:0]           wr_x_in,
    input  logic [11:0]           wr_y_in,
    input  logic [TIME_WIDTH-1:0] wr_time_in,
    input  logic                  wr_color_in,
    input  logic [11:0]           hand_x_left_in,
    input  logic [11:0]           hand_y_left_in,
    input  logic [11:0]           hand_x_right_in,
    input  logic [11:0]           hand_y_right_in,
    output logic [TIME_WIDTH-1:0] curr_time_out,
    output logic                  running_out,
    output logic                  scan_busy_out,
    output logic [NUM_BLOCKS-1:0] visible_mask_out,
    output logic [NUM_BLOCKS-1:0] hit_mask_out,
    output logic                  hit_pulse_out,
    output logic                  miss_pulse_out,
    output logic [15:0]           score_out,
    output logic [7:0]            combo_out
);

    localparam int CW = $clog2(CYCLES_PER_TICK);
    localparam logic [CW-1:0]         TICK_LAST = CW'(CYCLES_PER_TICK - 1);
    localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_BLOCKS - 1);
    localparam logic [TIME_WIDTH:0]   LOOK      = (TIME_WIDTH + 1)'(LOOKAHEAD);
    localparam logic [12:0]           RADIUS    = 13'(HIT_RADIUS);
    localparam logic [TIME_WIDTH-1:0] TIME_END  = '1;

    typedef enum logic [1:0] {IDLE, WAIT, SCAN} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]         tick_cnt;
    logic [IW-1:0]         scan_idx;
    logic [NUM_BLOCKS-1:0] valid;
    logic [NUM_BLOCKS-1:0] vis_shadow;
    logic [11:0]           hx_l, hy_l, hx_r, hy_r;

    // Table storage carries no reset; the valid bits qualify every entry.
    logic [11:0]           blk_x   [NUM_BLOCKS];
    logic [11:0]           blk_y   [NUM_BLOCKS];
    logic [TIME_WIDTH-1:0] blk_t   [NUM_BLOCKS];
    logic                  blk_c   [NUM_BLOCKS];

    always_ff @(posedge clk_in) begin
        if (wr_en_in) begin
            blk_x[wr_index_in] <= wr_x_in;
            blk_y[wr_index_in] <= wr_y_in;
            blk_t[wr_index_in] <= wr_time_in;
            blk_c[wr_index_in] <= wr_color_in;
        end
    end

    logic [11:0]           cur_x, cur_y, sel_hx, sel_hy;
    logic [TIME_WIDTH-1:0] cur_t, time_diff;
    logic                  cur_c;
    logic signed [12:0]    dx, dy;
    logic [12:0]           adx, ady;
    logic                  tick_done, last_entry, eval_live, vis, in_window, reach;
    logic                  do_hit, do_miss;
    logic [16:0]           score_sum;

    assign cur_x  = blk_x[scan_idx];
    assign cur_y  = blk_y[scan_idx];
    assign cur_t  = blk_t[scan_idx];
    assign cur_c  = blk_c[scan_idx];
    assign sel_hx = cur_c ? hx_r : hx_l;
    assign sel_hy = cur_c ? hy_r : hy_l;

    assign dx  = $signed({1'b0, sel_hx}) - $signed({1'b0, cur_x});
    assign dy  = $signed({1'b0, sel_hy}) - $signed({1'b0, cur_y});
    assign adx = dx[12] ? -dx : dx;
    assign ady = dy[12] ? -dy : dy;

    assign tick_done  = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign last_entry = (scan_idx == IDX_LAST);
    assign time_diff  = cur_t - curr_time_out;

    // A restart abandons the scan, so the entry in flight is not judged.
    assign eval_live = (state == SCAN) && !start_in && valid[scan_idx] && !hit_mask_out[scan_idx];
    assign vis       = eval_live && (cur_t >= curr_time_out) && ({1'b0, time_diff} <= LOOK);
    assign in_window = eval_live && (cur_t == curr_time_out);
    assign reach     = (adx <= RADIUS) && (ady <= RADIUS);
    assign do_hit    = in_window && reach;
    assign do_miss   = in_window && !reach;
    assign score_sum = {1'b0, score_out} + {9'd0, combo_out} + 17'd1;

    logic [NUM_BLOCKS-1:0] shadow_nxt, hit_mask_nxt;

    always_comb begin
        shadow_nxt           = vis_shadow;
        shadow_nxt[scan_idx] = vis;
        hit_mask_nxt         = hit_mask_out;
        if (start_in)
            hit_mask_nxt = '0;
        else if (do_hit)
            hit_mask_nxt[scan_idx] = 1'b1;
        // A rewrite starts the entry fresh, overriding a hit landing the same cycle.
        if (wr_en_in)
            hit_mask_nxt[wr_index_in] = 1'b0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_in) state_nxt = WAIT;
            WAIT: begin
                if (start_in)       state_nxt = WAIT;
                else if (tick_done) state_nxt = SCAN;
            end
            SCAN: begin
                if (start_in)        state_nxt = WAIT;
                else if (last_entry) state_nxt = (curr_time_out == TIME_END) ? IDLE : WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state            <= IDLE;
            tick_cnt         <= '0;
            scan_idx         <= '0;
            curr_time_out    <= '0;
            valid            <= '0;
            vis_shadow       <= '0;
            visible_mask_out <= '0;
            hit_mask_out     <= '0;
            hit_pulse_out    <= 1'b0;
            miss_pulse_out   <= 1'b0;
            score_out        <= '0;
            combo_out        <= '0;
            hx_l             <= '0;
            hy_l             <= '0;
            hx_r             <= '0;
            hy_r             <= '0;
        end else begin
            state        <= state_nxt;
            hit_mask_out <= hit_mask_nxt;
            if (wr_en_in)
                valid[wr_index_in] <= 1'b1;

            if (start_in) begin
                tick_cnt         <= '0;
                scan_idx         <= '0;
                curr_time_out    <= '0;
                vis_shadow       <= '0;
                visible_mask_out <= '0;
                hit_pulse_out    <= 1'b0;
                miss_pulse_out   <= 1'b0;
                score_out        <= '0;
                combo_out        <= '0;
            end else begin
                hit_pulse_out  <= do_hit;
                miss_pulse_out <= do_miss;
                if (state != IDLE)
                    tick_cnt <= tick_done ? '0 : tick_cnt + CW'(1);
                if (tick_done) begin
                    curr_time_out <= curr_time_out + TIME_WIDTH'(1);
                    scan_idx      <= '0;
                    hx_l          <= hand_x_left_in;
                    hy_l          <= hand_y_left_in;
                    hx_r          <= hand_x_right_in;
                    hy_r          <= hand_y_right_in;
                end
                if (state == SCAN) begin
                    vis_shadow <= shadow_nxt;
                    scan_idx   <= scan_idx + IW'(1);
                    if (last_entry)
                        visible_mask_out <= shadow_nxt;
                end
                if (do_hit) begin
                    score_out <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    if (combo_out != 8'hFF)
                        combo_out <= combo_out + 8'd1;
                end else if (do_miss) begin
                    combo_out <= '0;
                end
            end
        end
    end

    assign running_out   = (state != IDLE);
    assign scan_busy_out = (state == SCAN);

endmodule
